alu_mul_seq: RTL and testbench

- Multi-cycle 8x8 unsigned shift-and-add multiplier.
- Acts as the initiator on the combinational ALU's operand/op interface. Each cycle it drives `alu_a`, `alu_b` and `alu_op`, and samples `alu_result` and `alu_carry` in the same cycle.
- Produces a 16-bit product with a start/busy/done handshake. The datapath sequencer uses it for MUL without adding a hardware multiplier.

---
 rtl/alu_mul_seq.sv | 185 ++++++++++++++++++
 tb/tb_alu_mul_seq.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier that borrows the shared ALU for
// every add and shift. Optional product flags are enabled with ALU_MUL_FLAGS_EN.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [1:0]           alu_op,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_carry
`ifdef ALU_MUL_FLAGS_EN
  ,
  output logic                 prod_hi_nz,
  output logic                 prod_zero
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] OP_SHL = 2'b00;
  localparam logic [1:0] OP_SHR = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ADD   = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     p_q, p_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 c_add_q, c_add_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH-1:0]     alu_a_q, alu_a_d;
  logic [WIDTH-1:0]     alu_b_q, alu_b_d;
  logic [1:0]           alu_op_q, alu_op_d;
`ifdef ALU_MUL_FLAGS_EN
  logic                 prod_hi_nz_q, prod_hi_nz_d;
  logic                 prod_zero_q, prod_zero_d;
`endif

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    q_d       = q_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    c_add_d   = c_add_q;
    product_d = product_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    alu_a_d   = '0;
    alu_b_d   = '0;
    alu_op_d  = OP_SHL;
`ifdef ALU_MUL_FLAGS_EN
    prod_hi_nz_d = prod_hi_nz_q;
    prod_zero_d  = prod_zero_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          p_d     = '0;
          q_d     = mplier;
          m_d     = mcand;
          cnt_d   = '0;
          c_add_d = 1'b0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        p_d     = alu_result;
        c_add_d = alu_carry;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // The ALU shift drops the add carry, so it is reinserted as the new MSB of P.
        p_d     = {c_add_q, alu_result[WIDTH-2:0]};
        q_d     = {alu_carry, q_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_q == CNT_LAST) ? S_DONE : S_ADD;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    case (state_d)
      S_ADD: begin
        busy_d   = 1'b1;
        alu_op_d = OP_ADD;
        alu_a_d  = p_d;
        alu_b_d  = q_d[0] ? m_d : '0;
      end
      S_SHIFT: begin
        busy_d   = 1'b1;
        alu_op_d = OP_SHR;
        alu_a_d  = p_d;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase

    if (state_q == S_SHIFT && state_d == S_DONE) begin
      product_d = {p_d, q_d};
`ifdef ALU_MUL_FLAGS_EN
      prod_hi_nz_d = |p_d;
      prod_zero_d  = ~|{p_d, q_d};
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      c_add_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= OP_SHL;
`ifdef ALU_MUL_FLAGS_EN
      prod_hi_nz_q <= 1'b0;
      prod_zero_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      q_q       <= q_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      c_add_q   <= c_add_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
`ifdef ALU_MUL_FLAGS_EN
      prod_hi_nz_q <= prod_hi_nz_d;
      prod_zero_q  <= prod_zero_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_op  = alu_op_q;
`ifdef ALU_MUL_FLAGS_EN
  assign prod_hi_nz = prod_hi_nz_q;
  assign prod_zero  = prod_zero_q;
`endif

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed testbench for alu_mul_seq with a behavioural model of the combinational ALU.
// Flag checks are compiled in when ALU_MUL_FLAGS_EN is defined.
`timescale 1ns/1ps
module tb_alu_mul_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [1:0]  alu_op;
  logic [7:0]  alu_result;
  logic        alu_carry;
`ifdef ALU_MUL_FLAGS_EN
  logic        prod_hi_nz;
  logic        prod_zero;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_mul_seq #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mcand      (mcand),
    .mplier     (mplier),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carry  (alu_carry)
`ifdef ALU_MUL_FLAGS_EN
    ,
    .prod_hi_nz (prod_hi_nz),
    .prod_zero  (prod_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU: SHL, SHR (carry = bit shifted out), ADD (carry out), SUB (borrow).
  always_comb begin
    alu_result = 8'h00;
    alu_carry  = 1'b0;
    case (alu_op)
      2'b00:   {alu_carry, alu_result} = {alu_a, 1'b0};
      2'b01:   begin alu_result = {1'b0, alu_a[7:1]}; alu_carry = alu_a[0]; end
      2'b10:   {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      default: {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no completion, expected summary");
    $fatal(1, "watchdog");
  end

  task automatic start_mul(input logic [7:0] a, input logic [7:0] b);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Returns the number of edges after the start edge until done is seen (-1 on timeout).
  task automatic run_to_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; mcand = 8'h00; mplier = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, product, alu_a, alu_b, alu_op} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b product=%h a=%h b=%h op=%b, expected all 0",
               busy, done, product, alu_a, alu_b, alu_op);
    end
`ifdef ALU_MUL_FLAGS_EN
    n_checks++;
    if ({prod_hi_nz, prod_zero} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags: got hi_nz=%b zero=%b, expected 0 0", prod_hi_nz, prod_zero);
    end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat, bcnt;
    start_mul(8'd13, 8'd11);
    run_to_done(lat, bcnt);
    n_checks++;
    if (lat !== 16) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d, expected 16", lat);
    end
    n_checks++;
    if (bcnt !== 16) begin
      n_fail++;
      $display("FAIL basic_busy_cycles: got %0d, expected 16", bcnt);
    end
    n_checks++;
    if (product !== 16'h008F) begin
      n_fail++;
      $display("FAIL basic_product: got %h, expected 008f", product);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_width: got done=%b busy=%b, expected 0 0", done, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (product !== 16'h008F) begin
      n_fail++;
      $display("FAIL basic_product_hold: got %h, expected 008f", product);
    end
  endtask

  task automatic test_full_scale;
    int lat, bcnt;
    start_mul(8'hFF, 8'hFF);
    run_to_done(lat, bcnt);
    n_checks++;
    if (lat !== 16 || product !== 16'hFE01) begin
      n_fail++;
      $display("FAIL full_scale: got lat=%0d product=%h, expected 16 fe01", lat, product);
    end
`ifdef ALU_MUL_FLAGS_EN
    n_checks++;
    if ({prod_hi_nz, prod_zero} !== 2'b10) begin
      n_fail++;
      $display("FAIL full_scale_flags: got hi_nz=%b zero=%b, expected 1 0", prod_hi_nz, prod_zero);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_zero_operands;
    int lat, bcnt;
    start_mul(8'd0, 8'd200);
    run_to_done(lat, bcnt);
    n_checks++;
    if (lat !== 16 || product !== 16'h0000) begin
      n_fail++;
      $display("FAIL zero_mcand: got lat=%0d product=%h, expected 16 0000", lat, product);
    end
`ifdef ALU_MUL_FLAGS_EN
    n_checks++;
    if ({prod_hi_nz, prod_zero} !== 2'b01) begin
      n_fail++;
      $display("FAIL zero_mcand_flags: got hi_nz=%b zero=%b, expected 0 1", prod_hi_nz, prod_zero);
    end
`endif
    @(posedge clk); #1;
    start_mul(8'h80, 8'h01);
    run_to_done(lat, bcnt);
    n_checks++;
    if (lat !== 16 || product !== 16'h0080) begin
      n_fail++;
      $display("FAIL low_only: got lat=%0d product=%h, expected 16 0080", lat, product);
    end
`ifdef ALU_MUL_FLAGS_EN
    n_checks++;
    if ({prod_hi_nz, prod_zero} !== 2'b00) begin
      n_fail++;
      $display("FAIL low_only_flags: got hi_nz=%b zero=%b, expected 0 0", prod_hi_nz, prod_zero);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored;
    int ndone, lat, bcnt;
    logic [15:0] prod_at_done;
    ndone = 0;
    prod_at_done = 16'hxxxx;
    start_mul(8'd7, 8'd9);
    for (int i = 0; i < 17; i++) begin
      if (i == 5) begin start = 1'b1; mcand = 8'd3; mplier = 8'd3; end
      if (i == 6) start = 1'b0;
      if (done) begin
        ndone++;
        if (i == 16) prod_at_done = product;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (ndone !== 1) begin
      n_fail++;
      $display("FAIL ignored_done_count: got %0d, expected 1", ndone);
    end
    n_checks++;
    if (prod_at_done !== 16'h003F) begin
      n_fail++;
      $display("FAIL ignored_product: got %h, expected 003f", prod_at_done);
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_done_after: got %b, expected 0", done);
    end
    start_mul(8'd2, 8'd3);
    run_to_done(lat, bcnt);
    n_checks++;
    if (lat !== 16 || product !== 16'h0006) begin
      n_fail++;
      $display("FAIL back_to_back: got lat=%0d product=%h, expected 16 0006", lat, product);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int ndone, lat, bcnt;
    ndone = 0;
    start_mul(8'd200, 8'd200);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, product, alu_a, alu_b, alu_op} !== 36'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got busy=%b done=%b product=%h a=%h b=%h op=%b, expected all 0",
               busy, done, product, alu_a, alu_b, alu_op);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) ndone++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (ndone !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: got %0d active cycles, expected 0", ndone);
    end
    start_mul(8'd5, 8'd6);
    run_to_done(lat, bcnt);
    n_checks++;
    if (lat !== 16 || product !== 16'h001E) begin
      n_fail++;
      $display("FAIL after_reset_product: got lat=%0d product=%h, expected 16 001e", lat, product);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alu_interface;
    logic [7:0] mp, mq, mm, exp_b;
    logic [1:0] exp_op;
    logic       mc;
    mp = 8'd0; mq = 8'd11; mm = 8'd13; mc = 1'b0;
    n_checks++;
    if (alu_op !== 2'b00 || alu_a !== 8'h00 || alu_b !== 8'h00) begin
      n_fail++;
      $display("FAIL alu_idle: got op=%b a=%h b=%h, expected 00 00 00", alu_op, alu_a, alu_b);
    end
    start_mul(mm, mq);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        exp_op = 2'b10;
        exp_b  = mq[0] ? mm : 8'h00;
      end else begin
        exp_op = 2'b01;
        exp_b  = 8'h00;
      end
      n_checks++;
      if (alu_op !== exp_op || alu_a !== mp || alu_b !== exp_b) begin
        n_fail++;
        $display("FAIL alu_cycle%0d: got op=%b a=%h b=%h, expected %b %h %h",
                 i, alu_op, alu_a, alu_b, exp_op, mp, exp_b);
      end
      if (i % 2 == 0) {mc, mp} = {1'b0, mp} + {1'b0, exp_b};
      else {mc, mp, mq} = {1'b0, mc, mp, mq[7:1]};
      @(posedge clk); #1;
    end
    n_checks++;
    if (done !== 1'b1 || product !== {mp, mq} || alu_op !== 2'b00) begin
      n_fail++;
      $display("FAIL alu_final: got done=%b product=%h op=%b, expected 1 %h 00",
               done, product, alu_op, {mp, mq});
    end
    @(posedge clk); #1;
    n_checks++;
    if (alu_op !== 2'b00 || alu_a !== 8'h00 || alu_b !== 8'h00) begin
      n_fail++;
      $display("FAIL alu_idle_after: got op=%b a=%h b=%h, expected 00 00 00", alu_op, alu_a, alu_b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_scale();
    test_zero_operands();
    test_start_ignored();
    test_reset_mid();
    test_alu_interface();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
